// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage.
// Owns the program counter and drives the instruction-memory address.
// Loads the IF/ID pipeline register and applies jump/branch redirects
// that are resolved in ID/EX.
// Optional build macro JUMP_PREDECODE_EN adds IF-stage predecode of J/JAL.
// With the macro, unconditional jumps redirect without a bubble.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             if_id_valid,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pcp4,
  output logic             if_id_predecoded,
  output logic             redirect_taken,
  output logic [CNT_W-1:0] redirect_count
);

  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      pcp4;
  logic             valid_reg, valid_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      pcp4_reg, pcp4_next;
  logic             pred_reg, pred_next;
  logic             taken_reg, taken_next;
  logic [CNT_W-1:0] count_reg;
  logic             is_jump;

  // Sequential successor; wraps silently past 32'hFFFF_FFFC.
  assign pcp4 = pc_reg + 32'd4;

`ifdef JUMP_PREDECODE_EN
  // J (000010) and JAL (000011) share every opcode bit except the LSB.
  assign is_jump = (imem_rdata[31:27] == 5'b00001);
`else
  assign is_jump = 1'b0;
`endif

  // Next-state selection, highest priority first: redirect, stall, predecode, sequential.
  always_comb begin
    pc_next    = pcp4;
    valid_next = 1'b1;
    instr_next = imem_rdata;
    pcp4_next  = pcp4;
    pred_next  = 1'b0;
    taken_next = 1'b0;
    if (redirect_valid) begin
      // A redirect also overrides a stall: the held instruction is wrong-path.
      pc_next    = redirect_target;
      valid_next = 1'b0;
      instr_next = 32'h0;
      pcp4_next  = 32'h0;
      taken_next = 1'b1;
    end else if (stall) begin
      pc_next    = pc_reg;
      valid_next = valid_reg;
      instr_next = instr_reg;
      pcp4_next  = pcp4_reg;
      pred_next  = pred_reg;
    end else if (is_jump) begin
      // The jump itself still enters IF/ID so that JAL can write its link register.
      pc_next    = {pcp4[31:26], imem_rdata[25:0]};
      pred_next  = 1'b1;
      taken_next = 1'b1;
    end
  end

  // PC, IF/ID register and the redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b0;
      instr_reg <= 32'h0;
      pcp4_reg  <= 32'h0;
      pred_reg  <= 1'b0;
      taken_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      pcp4_reg  <= pcp4_next;
      pred_reg  <= pred_next;
      taken_reg <= taken_next;
    end
  end

  // Saturating count of applied redirects, both external and predecoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (taken_next && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign imem_addr        = pc_reg;
  assign if_id_valid      = valid_reg;
  assign if_id_instr      = instr_reg;
  assign if_id_pcp4       = pcp4_reg;
  assign if_id_predecoded = pred_reg;
  assign redirect_taken   = taken_reg;
  assign redirect_count   = count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit.
// The bench covers reset, sequential fetch, redirect, redirect during a stall,
// PC wrap, J predecode and counter saturation.
// The counter is built 4 bits wide so that saturation is reached quickly.
module tb_pc_fetch_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             if_id_valid;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pcp4;
  logic             if_id_predecoded;
  logic             redirect_taken;
  logic [CNT_W-1:0] redirect_count;

  logic             jword_en = 1'b0;
  int               n_checks = 0;
  int               n_fail   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_id_valid      (if_id_valid),
    .if_id_instr      (if_id_instr),
    .if_id_pcp4       (if_id_pcp4),
    .if_id_predecoded (if_id_predecoded),
    .redirect_taken   (redirect_taken),
    .redirect_count   (redirect_count)
  );

  always #5 clk = ~clk;

  // Address-tagged instruction memory; no word carries a J/JAL opcode unless jword_en is set.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  always_comb begin
    if (jword_en && imem_addr == 32'h0000_0040) imem_rdata = 32'h0800_0040;
    else imem_rdata = mem(imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic v,
                          input logic [31:0] instr, input logic [31:0] p4, input logic taken);
    chk({tag, " pc"}, imem_addr, pc);
    chk({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, v});
    chk({tag, " instr"}, if_id_instr, instr);
    chk({tag, " pcp4"}, if_id_pcp4, p4);
    chk({tag, " taken"}, {31'h0, redirect_taken}, {31'h0, taken});
    $display("step %-12s pc=%h valid=%0b instr=%h pcp4=%h pred=%0b taken=%0b cnt=%0d",
             tag, imem_addr, if_id_valid, if_id_instr, if_id_pcp4, if_id_predecoded,
             redirect_taken, redirect_count);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick();
    chk_ifid("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset pred", {31'h0, if_id_predecoded}, 32'h0);
    chk("reset cnt", {28'h0, redirect_count}, 32'h0);

    // Free-run from reset.
    rst = 1'b0;
    chk("first pc", imem_addr, 32'h0);
    tick(); chk_ifid("seq1", 32'h4, 1'b1, mem(32'h0), 32'h4, 1'b0);
    tick(); chk_ifid("seq2", 32'h8, 1'b1, mem(32'h4), 32'h8, 1'b0);
    tick(); chk_ifid("seq3", 32'hC, 1'b1, mem(32'h8), 32'hC, 1'b0);
    tick(); chk("seq4 pc", imem_addr, 32'h10);

    // External redirect at pc=0x10.
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick(); chk_ifid("redir", 32'h100, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("redir cnt", {28'h0, redirect_count}, 32'd1);
    redirect_valid = 1'b0;
    tick(); chk_ifid("redir+2", 32'h104, 1'b1, mem(32'h100), 32'h104, 1'b0);
    chk("redir+2 cnt", {28'h0, redirect_count}, 32'd1);

    // Reach pc=0x20 with the 0x1C instruction in IF/ID, then stall 3 cycles.
    redirect_valid = 1'b1; redirect_target = 32'h1C;
    tick(); redirect_valid = 1'b0;
    tick(); chk_ifid("pre-stall", 32'h20, 1'b1, mem(32'h1C), 32'h20, 1'b0);
    stall = 1'b1;
    tick(); chk_ifid("stall1", 32'h20, 1'b1, mem(32'h1C), 32'h20, 1'b0);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    tick(); chk_ifid("stall-redir", 32'h200, 1'b0, 32'h0, 32'h0, 1'b1);
    redirect_valid = 1'b0;
    tick(); chk_ifid("stall3", 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);
    stall = 1'b0;
    tick(); chk_ifid("resume", 32'h204, 1'b1, mem(32'h200), 32'h204, 1'b0);
    chk("resume cnt", {28'h0, redirect_count}, 32'd3);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0;
    tick(); chk_ifid("wrap-1", 32'hFFFF_FFFC, 1'b1, mem(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b0);
    tick(); chk_ifid("wrap", 32'h0, 1'b1, mem(32'hFFFF_FFFC), 32'h0, 1'b0);
    chk("wrap cnt", {28'h0, redirect_count}, 32'd4);

    // J at 0x40 targeting 0x40.
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick(); redirect_valid = 1'b0;
    jword_en = 1'b1;
    tick(); jword_en = 1'b0;
`ifdef JUMP_PREDECODE_EN
    chk_ifid("jpre", 32'h40, 1'b1, 32'h0800_0040, 32'h44, 1'b1);
    chk("jpre pred", {31'h0, if_id_predecoded}, 32'h1);
    chk("jpre cnt", {28'h0, redirect_count}, 32'd6);
`else
    chk_ifid("jseq", 32'h44, 1'b1, 32'h0800_0040, 32'h44, 1'b0);
    chk("jseq pred", {31'h0, if_id_predecoded}, 32'h0);
    chk("jseq cnt", {28'h0, redirect_count}, 32'd5);
`endif
    tick(); chk("after j pred", {31'h0, if_id_predecoded}, 32'h0);

    // 2^CNT_W+2 back-to-back redirects saturate the counter.
    redirect_valid = 1'b1; redirect_target = 32'h300;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) tick();
    chk_ifid("sat", 32'h300, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("sat cnt", {28'h0, redirect_count}, 32'd15);
    redirect_valid = 1'b0;
    tick(); chk("sat hold cnt", {28'h0, redirect_count}, 32'd15);

    // Reset mid-operation with a redirect pending.
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h500;
    tick(); chk_ifid("rst2", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst2 cnt", {28'h0, redirect_count}, 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    tick(); chk_ifid("rst2+1", 32'h4, 1'b1, mem(32'h0), 32'h4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
